// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants and the sprite draw FSM state type.
// 64x32 monochrome framebuffer, one bit per pixel.
package chip8_pkg;

   localparam int SCREEN_W       = 64;
   localparam int SCREEN_H       = 32;
   localparam int FB_AW          = 11;
   localparam int SPR_ROW_CYCLES = 18;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      PIXRD,
      PIXWR,
      CLR,
      DONE
   } draw_state_t;

endpackage

// File: rtl/sprite_draw_engine.sv
// XOR sprite blitter and full-screen clear for a 64x32 1bpp framebuffer.
// Sprite memory and framebuffer RAM are external, both with 1-cycle read latency.
module sprite_draw_engine
   import chip8_pkg::*;
#(
   parameter int SPR_AW = 12,
   parameter int FB_AW  = 11
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              draw,
   input  logic              clear,
   input  logic [7:0]        destx,
   input  logic [7:0]        desty,
   input  logic [3:0]        spriteh,
   input  logic [SPR_AW-1:0] spr_base,
   output logic [SPR_AW-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [FB_AW-1:0]  fb_addr,
   input  logic              fb_rdata,
   output logic              fb_we,
   output logic              fb_wdata,
   output logic              busy,
   output logic              drawdone,
   output logic              collision
);

   draw_state_t       state, nxt;
   logic [5:0]        x0;
   logic [4:0]        y0;
   logic [3:0]        h_q;
   logic [3:0]        row;
   logic [2:0]        col;
   logic [SPR_AW-1:0] base_q;
   logic [7:0]        sr;
   logic [FB_AW-1:0]  clr_addr;
   logic [SPR_AW-1:0] mem_addr_q;
   logic [FB_AW-1:0]  fb_addr_q;
   logic [5:0]        pix_x;
   logic [4:0]        pix_y;
   logic [FB_AW-1:0]  pix_addr;
   logic              accept;
   logic              last_row;
   logic              unused_in;

   // Only the on-screen coordinate bits matter; the rest are discarded.
   assign unused_in = ^{destx[7:6], desty[7:5]};

   assign accept   = (state == IDLE) && (draw || clear);
   assign last_row = (row == h_q - 4'd1);
   assign pix_x    = x0 + {3'b000, col};
   assign pix_y    = y0 + {1'b0, row};
   assign pix_addr = FB_AW'({pix_y, pix_x});

   assign busy     = (state != IDLE);
   assign drawdone = (state == DONE);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (clear)
               nxt = CLR;
            else if (draw)
               nxt = (spriteh == 4'd0) ? DONE : FETCH;
         end
         FETCH: nxt = LATCH;
         LATCH: nxt = PIXRD;
         PIXRD: nxt = PIXWR;
         PIXWR: begin
            if (col != 3'd7)
               nxt = PIXRD;
            else
               nxt = last_row ? DONE : FETCH;
         end
         CLR: begin
            if (clr_addr == {FB_AW{1'b1}})
               nxt = DONE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Addresses are held in registers so they keep their value when idle.
   always_comb begin
      mem_addr = mem_addr_q;
      fb_addr  = fb_addr_q;
      fb_we    = 1'b0;
      fb_wdata = 1'b0;
      unique case (state)
         FETCH: mem_addr = base_q + SPR_AW'(row);
         PIXRD: fb_addr = pix_addr;
         PIXWR: begin
            fb_addr  = pix_addr;
            fb_we    = sr[7];
            fb_wdata = ~fb_rdata;
         end
         CLR: begin
            fb_addr = clr_addr;
            fb_we   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         x0         <= '0;
         y0         <= '0;
         h_q        <= '0;
         row        <= '0;
         col        <= '0;
         base_q     <= '0;
         sr         <= '0;
         clr_addr   <= '0;
         mem_addr_q <= '0;
         fb_addr_q  <= '0;
         collision  <= 1'b0;
      end else begin
         state      <= nxt;
         mem_addr_q <= mem_addr;
         fb_addr_q  <= fb_addr;
         if (accept) begin
            x0        <= destx[5:0];
            y0        <= desty[4:0];
            h_q       <= spriteh;
            base_q    <= spr_base;
            row       <= '0;
            col       <= '0;
            clr_addr  <= '0;
            collision <= 1'b0;
         end
         unique case (state)
            LATCH: begin
               sr  <= mem_rdata;
               col <= '0;
            end
            PIXWR: begin
               // A lit pixel under a set sprite bit is about to go dark.
               if (sr[7] && fb_rdata)
                  collision <= 1'b1;
               sr  <= {sr[6:0], 1'b0};
               col <= col + 3'd1;
               if (col == 3'd7)
                  row <= row + 4'd1;
            end
            CLR: clr_addr <= clr_addr + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine with behavioural sprite ROM and framebuffer.
// Expected pixels, latencies and addresses are hand-computed constants.
module tb_sprite_draw_engine;

   localparam int SPR_AW = 12;
   localparam int FB_AW  = 11;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic              draw = 1'b0;
   logic              clear = 1'b0;
   logic [7:0]        destx = '0;
   logic [7:0]        desty = '0;
   logic [3:0]        spriteh = '0;
   logic [SPR_AW-1:0] spr_base = '0;
   logic [SPR_AW-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [FB_AW-1:0]  fb_addr;
   logic              fb_rdata;
   logic              fb_we;
   logic              fb_wdata;
   logic              busy;
   logic              drawdone;
   logic              collision;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [7:0] spr_mem [4096];
   bit         fb [2048];

   int we_cnt = 0;
   int one_cnt = 0;
   int dd_cnt = 0;
   int run = 0;
   int prev_addr = 0;

   sprite_draw_engine #(.SPR_AW(SPR_AW), .FB_AW(FB_AW)) dut (
      .Clk(Clk), .Reset(Reset), .draw(draw), .clear(clear),
      .destx(destx), .desty(desty), .spriteh(spriteh), .spr_base(spr_base),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .fb_addr(fb_addr), .fb_rdata(fb_rdata),
      .fb_we(fb_we), .fb_wdata(fb_wdata),
      .busy(busy), .drawdone(drawdone), .collision(collision)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      cyc++;
      mem_rdata <= spr_mem[mem_addr];
      fb_rdata  <= fb[fb_addr];
      if (fb_we)
         fb[fb_addr] <= fb_wdata;
   end

   always @(negedge Clk) begin
      if (drawdone)
         dd_cnt++;
      if (fb_we) begin
         we_cnt++;
         if (fb_wdata)
            one_cnt++;
         if (fb_addr == 0)
            run = 1;
         else if (int'(fb_addr) == prev_addr + 1)
            run++;
         else
            run = 0;
         prev_addr = int'(fb_addr);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] row8(input int y, input int x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++)
         r[7-i] = fb[(y % 32) * 64 + ((x + i) % 64)];
      return r;
   endfunction

   function automatic int fb_ones();
      int n = 0;
      for (int i = 0; i < 2048; i++)
         n += int'(fb[i]);
      return n;
   endfunction

   task automatic start(input bit d, input bit c, input logic [7:0] dx,
                        input logic [7:0] dy, input logic [3:0] h,
                        input logic [11:0] b, output int t0);
      @(negedge Clk);
      draw = d; clear = c;
      destx = dx; desty = dy; spriteh = h; spr_base = b;
      t0 = cyc;
      @(negedge Clk);
      draw = 1'b0; clear = 1'b0;
      destx = 8'hAA; desty = 8'h77; spriteh = 4'hF; spr_base = 12'hFFF;
      check("busy_after_accept", busy, 1);
   endtask

   task automatic wait_done(input string tag, input int t0,
                            input int exp_lat, input int limit);
      int lat = -1;
      for (int i = 0; i < limit; i++) begin
         if (drawdone) begin
            lat = cyc - t0;
            break;
         end
         @(negedge Clk);
      end
      check(tag, lat, exp_lat);
      @(negedge Clk);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_dd_pulse"}, drawdone, 0);
   endtask

   initial begin
      int t0, we0, one0, dd0;

      spr_mem[100] = 8'hF0;
      spr_mem[200] = 8'hFF;
      spr_mem[201] = 8'h81;
      for (int i = 0; i < 8; i++)
         spr_mem[300+i] = 8'h3C;
      spr_mem[400] = 8'hA5;

      repeat (3) @(negedge Clk);
      check("rst_busy", busy, 0);
      check("rst_drawdone", drawdone, 0);
      check("rst_collision", collision, 0);
      check("rst_fb_we", fb_we, 0);
      check("rst_fb_wdata", fb_wdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_fb_addr", fb_addr, 0);
      Reset = 1'b0;

      start(1, 0, 8'd0, 8'd0, 4'd1, 12'd100, t0);
      wait_done("draw1_lat", t0, 19, 100);
      check("draw1_row0", row8(0, 0), 8'hF0);
      check("draw1_count", fb_ones(), 4);
      check("draw1_coll", collision, 0);

      start(1, 0, 8'd0, 8'd0, 4'd1, 12'd100, t0);
      wait_done("draw2_lat", t0, 19, 100);
      check("draw2_row0", row8(0, 0), 8'h00);
      check("draw2_count", fb_ones(), 0);
      check("draw2_coll", collision, 1);

      start(1, 0, 8'hFE, 8'hFF, 4'd2, 12'd200, t0);
      check("wrap_coll_cleared", collision, 0);
      wait_done("wrap_lat", t0, 37, 200);
      check("wrap_row31", row8(31, 62), 8'hFF);
      check("wrap_row0", row8(0, 62), 8'h81);
      check("wrap_count", fb_ones(), 10);
      check("wrap_coll", collision, 0);
      check("wrap_mem_hold", mem_addr, 201);
      check("wrap_fb_hold", fb_addr, 5);

      we0 = we_cnt;
      start(1, 0, 8'd3, 8'd3, 4'd0, 12'd100, t0);
      wait_done("h0_lat", t0, 1, 50);
      check("h0_no_we", we_cnt - we0, 0);
      check("h0_count", fb_ones(), 10);

      we0 = we_cnt;
      one0 = one_cnt;
      start(1, 1, 8'd0, 8'd0, 4'd1, 12'd100, t0);
      repeat (100) @(negedge Clk);
      draw = 1'b1;
      @(negedge Clk);
      draw = 1'b0;
      wait_done("clr_lat", t0, 2049, 2200);
      check("clr_writes", we_cnt - we0, 2048);
      check("clr_ascend", run, 2048);
      check("clr_last_addr", prev_addr, 2047);
      check("clr_ones", one_cnt - one0, 0);
      check("clr_count", fb_ones(), 0);
      check("clr_coll", collision, 0);
      repeat (3) @(negedge Clk);
      check("clr_no_queue", busy, 0);

      dd0 = dd_cnt;
      start(1, 0, 8'd0, 8'd20, 4'd8, 12'd300, t0);
      repeat (58) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check("abort_busy", busy, 0);
      check("abort_dd", drawdone, 0);
      check("abort_we", fb_we, 0);
      check("abort_mem_addr", mem_addr, 0);
      check("abort_fb_addr", fb_addr, 0);
      Reset = 1'b0;
      repeat (200) @(negedge Clk);
      check("abort_no_done", dd_cnt - dd0, 0);
      check("abort_row20", row8(20, 0), 8'h3C);
      check("abort_row23", row8(23, 0), 8'h00);

      start(1, 0, 8'd10, 8'd3, 4'd1, 12'd400, t0);
      wait_done("post_lat", t0, 19, 100);
      check("post_row3", row8(3, 10), 8'hA5);
      check("post_coll", collision, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
